// File: rtl/axi_rd_burst_splitter.sv
// axi_rd_burst_splitter
// AXI4 read-channel splitter between the Fletcher read master and the 512-bit
// CL bus. Each upstream AR burst (up to 256 beats of 64 bytes) is cut into
// downstream bursts that never cross a BOUNDARY-byte line and never exceed
// MAX_BEATS beats. A small FIFO of "last piece" flags re-merges the returned
// pieces so the upstream side sees exactly one rlast per logical burst.
//
// Optional feature macro: ARSPLIT_RESP_STICKY_EN
//   defined   : s_rresp carries the worst rresp seen so far in the burst
//   undefined : s_rresp follows m_rresp beat by beat
//
// Handshake rule (both AR and R channels): a transfer happens on a rising clk
// edge where valid and ready are both 1; a source never withdraws valid or
// changes payload while valid is high and ready is low (reset excepted), and
// ready may depend combinationally on valid.

module axi_rd_burst_splitter #(
  parameter int MAX_BEATS  = 64,
  parameter int BOUNDARY   = 4096,
  parameter int FIFO_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,

  input  logic [15:0]  s_arid,
  input  logic [63:0]  s_araddr,
  input  logic [7:0]   s_arlen,
  input  logic [2:0]   s_arsize,
  input  logic         s_arvalid,
  output logic         s_arready,

  output logic [15:0]  s_rid,
  output logic [511:0] s_rdata,
  output logic [1:0]   s_rresp,
  output logic         s_rlast,
  output logic         s_rvalid,
  input  logic         s_rready,

  output logic [15:0]  m_arid,
  output logic [63:0]  m_araddr,
  output logic [7:0]   m_arlen,
  output logic [2:0]   m_arsize,
  output logic         m_arvalid,
  input  logic         m_arready,

  input  logic [15:0]  m_rid,
  input  logic [511:0] m_rdata,
  input  logic [1:0]   m_rresp,
  input  logic         m_rlast,
  input  logic         m_rvalid,
  output logic         m_rready
);

  // Width bookkeeping for the boundary arithmetic.
  localparam int BW = $clog2(BOUNDARY);       // byte-offset bits within a boundary
  localparam int TW = BW - 5;                 // holds BOUNDARY/64 inclusive
  localparam int CW = (TW > 9) ? TW : 9;      // common compare width for the min()
  localparam int PW = $clog2(FIFO_DEPTH);     // FIFO pointer width

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [63:0]   addr_q, addr_d;
  logic [8:0]    rem_q, rem_d;
  logic [15:0]   id_q, id_d;

  // Tracking FIFO: one flag per outstanding downstream burst, 1 = final piece.
  logic          fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          fifo_full, fifo_empty, head_last;
  logic          push, push_last, pop;

  // Piece sizing.
  logic [BW-1:0] off_beats;
  logic [TW-1:0] tob;
  logic [CW-1:0] tob_w, rem_w, max_w, piece_w;
  logic [8:0]    piece;

  // The upstream size field is fixed at 64-byte beats and carries no information.
  logic          unused_arsize;
  assign unused_arsize = ^s_arsize;

  assign fifo_full  = (count_q == (PW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head_last  = fifo_mem_q[rd_ptr_q];

  // Beats left before the next boundary, and the size of the piece to issue now.
  always_comb begin
    off_beats = addr_q[BW-1:0] >> 6;
    tob       = TW'(BOUNDARY >> 6) - TW'(off_beats);
    tob_w     = CW'(tob);
    rem_w     = CW'(rem_q);
    max_w     = CW'(MAX_BEATS);
    piece_w   = rem_w;
    if (max_w < piece_w) piece_w = max_w;
    if (tob_w < piece_w) piece_w = tob_w;
    piece     = piece_w[8:0];
  end

  // Downstream request fields come straight from the working registers.
  assign m_araddr  = addr_q;
  assign m_arlen   = 8'(piece - 9'd1);
  assign m_arid    = id_q;
  assign m_arsize  = 3'd6;

  assign push      = m_arvalid & m_arready;
  assign push_last = (rem_q == piece);

  // FSM next state: accept a request in IDLE, issue pieces in SPLIT.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    id_d      = id_q;
    s_arready = 1'b0;
    m_arvalid = 1'b0;
    case (state_q)
      IDLE: begin
        s_arready = ~fifo_full & ~rst;
        if (s_arvalid && s_arready) begin
          addr_d  = s_araddr;
          rem_d   = {1'b0, s_arlen} + 9'd1;
          id_d    = s_arid;
          state_d = SPLIT;
        end
      end
      SPLIT: begin
        m_arvalid = ~fifo_full & ~rst;
        if (m_arvalid && m_arready) begin
          // Later pieces are always beat aligned; only the first keeps addr[5:0].
          addr_d = {addr_q[63:6] + 58'(piece), 6'b0};
          rem_d  = rem_q - piece;
          if (push_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and working registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      id_q    <= id_d;
    end
  end

  // R path is a pure wire-through; reset masks the handshake signals.
  assign s_rid    = m_rid;
  assign s_rdata  = m_rdata;
  assign s_rvalid = m_rvalid & ~rst;
  assign m_rready = s_rready & ~rst;
  // An empty FIFO here means the downstream broke ordering; pass rlast as-is.
  assign s_rlast  = m_rlast & (fifo_empty | head_last);
  assign pop      = m_rvalid & m_rready & m_rlast & ~fifo_empty;

  // Occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy; reset discards all tracked bursts.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // FIFO storage, no reset needed since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= push_last;
  end

`ifdef ARSPLIT_RESP_STICKY_EN
  logic [1:0] resp_q, resp_d;

  // Worst response so far in this logical burst, cleared after its final beat.
  always_comb begin
    s_rresp = (resp_q > m_rresp) ? resp_q : m_rresp;
    resp_d  = resp_q;
    if (s_rvalid && s_rready) begin
      resp_d = s_rlast ? 2'b00 : s_rresp;
    end
  end

  // Sticky response register.
  always_ff @(posedge clk) begin
    if (rst) resp_q <= 2'b00;
    else     resp_q <= resp_d;
  end
`else
  assign s_rresp = m_rresp;
`endif

endmodule

// File: tb/tb_axi_rd_burst_splitter.sv
// Testbench for axi_rd_burst_splitter: directed table of AR requests with
// hand-computed downstream pieces, R-path merge checks, plus hand-written
// sequences for reset, FIFO backpressure and sticky responses.

module tb_axi_rd_burst_splitter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT (default parameters) ----------------
  logic [15:0]  s_arid;   logic [63:0] s_araddr; logic [7:0] s_arlen; logic [2:0] s_arsize;
  logic         s_arvalid, s_arready;
  logic [15:0]  s_rid;    logic [511:0] s_rdata; logic [1:0] s_rresp;
  logic         s_rlast, s_rvalid, s_rready;
  logic [15:0]  m_arid;   logic [63:0] m_araddr; logic [7:0] m_arlen; logic [2:0] m_arsize;
  logic         m_arvalid, m_arready;
  logic [15:0]  m_rid;    logic [511:0] m_rdata; logic [1:0] m_rresp;
  logic         m_rlast, m_rvalid, m_rready;

  axi_rd_burst_splitter u_dut (
    .clk(clk), .rst(rst),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  // ---------------- DUT with a 2-deep tracking FIFO ----------------
  logic [15:0]  s_arid_b;   logic [63:0] s_araddr_b; logic [7:0] s_arlen_b; logic [2:0] s_arsize_b;
  logic         s_arvalid_b, s_arready_b;
  logic [15:0]  s_rid_b;    logic [511:0] s_rdata_b; logic [1:0] s_rresp_b;
  logic         s_rlast_b, s_rvalid_b, s_rready_b;
  logic [15:0]  m_arid_b;   logic [63:0] m_araddr_b; logic [7:0] m_arlen_b; logic [2:0] m_arsize_b;
  logic         m_arvalid_b, m_arready_b;
  logic [15:0]  m_rid_b;    logic [511:0] m_rdata_b; logic [1:0] m_rresp_b;
  logic         m_rlast_b, m_rvalid_b, m_rready_b;

  axi_rd_burst_splitter #(.MAX_BEATS(64), .BOUNDARY(4096), .FIFO_DEPTH(2)) u_dut_bp (
    .clk(clk), .rst(rst),
    .s_arid(s_arid_b), .s_araddr(s_araddr_b), .s_arlen(s_arlen_b), .s_arsize(s_arsize_b),
    .s_arvalid(s_arvalid_b), .s_arready(s_arready_b),
    .s_rid(s_rid_b), .s_rdata(s_rdata_b), .s_rresp(s_rresp_b), .s_rlast(s_rlast_b),
    .s_rvalid(s_rvalid_b), .s_rready(s_rready_b),
    .m_arid(m_arid_b), .m_araddr(m_araddr_b), .m_arlen(m_arlen_b), .m_arsize(m_arsize_b),
    .m_arvalid(m_arvalid_b), .m_arready(m_arready_b),
    .m_rid(m_rid_b), .m_rdata(m_rdata_b), .m_rresp(m_rresp_b), .m_rlast(m_rlast_b),
    .m_rvalid(m_rvalid_b), .m_rready(m_rready_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [71:0] exp_q[$];   // {piece address, piece arlen}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [63:0]      araddr;
    logic [7:0]       arlen;
    int               n;
    logic [3:0][63:0] p_addr;
    logic [3:0][7:0]  p_len;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [63:0] a, input logic [7:0] l, input int n,
                         input logic [63:0] a0, input logic [7:0] l0,
                         input logic [63:0] a1, input logic [7:0] l1,
                         input logic [63:0] a2, input logic [7:0] l2,
                         input logic [63:0] a3, input logic [7:0] l3);
    vec_t v;
    v.araddr = a; v.arlen = l; v.n = n;
    v.p_addr[0] = a0; v.p_len[0] = l0;
    v.p_addr[1] = a1; v.p_len[1] = l1;
    v.p_addr[2] = a2; v.p_len[2] = l2;
    v.p_addr[3] = a3; v.p_len[3] = l3;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  // Issue one upstream request and collect its downstream pieces, with
  // random m_arready stalls after the first piece.
  task automatic run_ar(input vec_t v, input logic [15:0] id);
    int t; int k; logic hold; logic [63:0] hold_addr; logic [71:0] e;
    exp_q.delete();
    for (int i = 0; i < v.n; i++) exp_q.push_back({v.p_addr[i], v.p_len[i]});
    @(negedge clk);
    s_arvalid = 1'b1; s_araddr = v.araddr; s_arlen = v.arlen; s_arid = id; s_arsize = 3'd6;
    m_arready = 1'b1;
    #1;
    t = 0;
    while (!s_arready && t < 50) begin @(negedge clk); #1; t++; end
    check("ar_accept", {63'd0, s_arready}, 64'd1);
    @(negedge clk);
    s_arvalid = 1'b0;
    #1;
    check("first_piece_latency", {63'd0, m_arvalid}, 64'd1);
    k = 0; t = 0; hold = 1'b0; hold_addr = '0;
    while (k < v.n && t < 300) begin
      if (hold) begin
        check("m_arvalid_held", {63'd0, m_arvalid}, 64'd1);
        check("m_araddr_stable", m_araddr, hold_addr);
      end
      hold = 1'b0;
      if (m_arvalid && m_arready) begin
        e = exp_q.pop_front();
        check("m_araddr", m_araddr, e[71:8]);
        check("m_arlen", {56'd0, m_arlen}, {56'd0, e[7:0]});
        check("m_arid", {48'd0, m_arid}, {48'd0, id});
        check("m_arsize", {61'd0, m_arsize}, 64'd6);
        k++;
      end else if (m_arvalid) begin
        hold = 1'b1; hold_addr = m_araddr;
      end
      @(negedge clk);
      m_arready = ($urandom_range(0, 3) != 0);
      t++;
      #1;
    end
    check("pieces_issued", 64'(k), 64'(v.n));
    check("idle_after_last", {63'd0, m_arvalid}, 64'd0);
    check("ar_ready_after_last", {63'd0, s_arready}, 64'd1);
    m_arready = 1'b1;
  endtask

  // Return all beats of the pieces of v in order; err_beat (1-based, 0 = none)
  // carries SLVERR on m_rresp.
  task automatic run_r(input vec_t v, input int err_beat);
    int beat; int total; logic [1:0] exp_resp;
    beat = 0; total = int'(v.arlen) + 1;
    for (int i = 0; i < v.n; i++) begin
      for (int b = 0; b <= int'(v.p_len[i]); b++) begin
        beat++;
        @(negedge clk);
        m_rvalid = 1'b1; s_rready = 1'b1;
        m_rdata  = {8{64'(beat)}};
        m_rid    = 16'hA000 + 16'(i);
        m_rlast  = (b == int'(v.p_len[i]));
        m_rresp  = (beat == err_beat) ? 2'd2 : 2'd0;
        #1;
`ifdef ARSPLIT_RESP_STICKY_EN
        exp_resp = (err_beat != 0 && beat >= err_beat) ? 2'd2 : 2'd0;
`else
        exp_resp = (beat == err_beat) ? 2'd2 : 2'd0;
`endif
        check("s_rlast", {63'd0, s_rlast}, {63'd0, (beat == total)});
        check("s_rresp", {62'd0, s_rresp}, {62'd0, exp_resp});
        if (b == 0 || beat == total) begin
          check("s_rvalid", {63'd0, s_rvalid}, 64'd1);
          check("m_rready", {63'd0, m_rready}, 64'd1);
          check("s_rdata_lo", s_rdata[63:0], 64'(beat));
          check("s_rdata_hi", s_rdata[511:448], 64'(beat));
          check("s_rid", {48'd0, s_rid}, {48'd0, 16'hA000 + 16'(i)});
        end
      end
    end
    @(negedge clk);
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'd0;
    #1;
    check("s_rvalid_idle", {63'd0, s_rvalid}, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Expected pieces worked by hand for MAX_BEATS 64, BOUNDARY 4096.
    add_vec(64'h0, 8'd255, 4, 64'h0, 8'd63, 64'h1000, 8'd63, 64'h2000, 8'd63, 64'h3000, 8'd63);
    add_vec(64'hFC0, 8'd3, 2, 64'hFC0, 8'd0, 64'h1000, 8'd2, 64'h0, 8'd0, 64'h0, 8'd0);
    add_vec(64'h2000, 8'd0, 1, 64'h2000, 8'd0, 64'h0, 8'd0, 64'h0, 8'd0, 64'h0, 8'd0);
    add_vec(64'h1F00, 8'd9, 2, 64'h1F00, 8'd3, 64'h2000, 8'd5, 64'h0, 8'd0, 64'h0, 8'd0);
    add_vec(64'h1005, 8'd1, 1, 64'h1005, 8'd1, 64'h0, 8'd0, 64'h0, 8'd0, 64'h0, 8'd0);
    add_vec(64'hFF80, 8'd69, 3, 64'hFF80, 8'd1, 64'h10000, 8'd63, 64'h11000, 8'd3, 64'h0, 8'd0);
    add_vec(64'hFC5, 8'd1, 2, 64'hFC5, 8'd0, 64'h1000, 8'd0, 64'h0, 8'd0, 64'h0, 8'd0);
    add_vec(64'hFFFF_FFFF_FFFF_FFC0, 8'd1, 2, 64'hFFFF_FFFF_FFFF_FFC0, 8'd0, 64'h0, 8'd0, 64'h0, 8'd0, 64'h0, 8'd0);
    add_vec(64'h0, 8'd127, 2, 64'h0, 8'd63, 64'h1000, 8'd63, 64'h0, 8'd0, 64'h0, 8'd0);

    // Idle values for both instances; R inputs active to prove reset gating.
    rst = 1'b1;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = 3'd6; s_arvalid = 1'b0; s_rready = 1'b1;
    m_arready = 1'b1; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b1;
    s_arid_b = '0; s_araddr_b = '0; s_arlen_b = '0; s_arsize_b = 3'd6; s_arvalid_b = 1'b0; s_rready_b = 1'b1;
    m_arready_b = 1'b1; m_rid_b = '0; m_rdata_b = '0; m_rresp_b = '0; m_rlast_b = 1'b0; m_rvalid_b = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_s_arready", {63'd0, s_arready}, 64'd0);
    check("rst_m_arvalid", {63'd0, m_arvalid}, 64'd0);
    check("rst_s_rvalid", {63'd0, s_rvalid}, 64'd0);
    check("rst_m_rready", {63'd0, m_rready}, 64'd0);
    @(negedge clk);
    rst = 1'b0; m_rvalid = 1'b0;
    #1;
    check("post_rst_s_arready", {63'd0, s_arready}, 64'd1);
    check("post_rst_m_arvalid", {63'd0, m_arvalid}, 64'd0);

    // Table-driven requests; the last entry carries SLVERR on beat 10.
    for (int i = 0; i < vecs.size(); i++) begin
      run_ar(vecs[i], 16'h0100 + 16'(i));
      run_r(vecs[i], (i == vecs.size() - 1) ? 10 : 0);
    end
    // Next burst after the error: response must be OKAY again.
    run_ar(vecs[2], 16'h0200);
    run_r(vecs[2], 0);

    // Reset after the first of four pieces.
    @(negedge clk);
    s_arvalid = 1'b1; s_araddr = 64'h0; s_arlen = 8'd255; s_arid = 16'h0300; m_arready = 1'b1;
    #1;
    check("mid_ar_accept", {63'd0, s_arready}, 64'd1);
    @(negedge clk);
    s_arvalid = 1'b0;
    #1;
    check("mid_piece0_valid", {63'd0, m_arvalid}, 64'd1);
    check("mid_piece0_addr", m_araddr, 64'h0);
    @(negedge clk);
    m_arready = 1'b0; rst = 1'b1; m_rvalid = 1'b1;
    #1;
    check("mid_rst_s_arready", {63'd0, s_arready}, 64'd0);
    check("mid_rst_s_rvalid", {63'd0, s_rvalid}, 64'd0);
    check("mid_rst_m_rready", {63'd0, m_rready}, 64'd0);
    @(negedge clk);
    rst = 1'b0; m_rvalid = 1'b0;
    #1;
    check("mid_rst_m_arvalid", {63'd0, m_arvalid}, 64'd0);
    check("mid_rst_s_arready", {63'd0, s_arready}, 64'd1);
    // With the FIFO emptied, a stray rlast passes straight through.
    @(negedge clk);
    m_rvalid = 1'b1; m_rlast = 1'b1;
    #1;
    check("empty_fifo_rlast", {63'd0, s_rlast}, 64'd1);
    @(negedge clk);
    m_rvalid = 1'b0; m_rlast = 1'b0; m_arready = 1'b1;
    run_ar(vecs[2], 16'h0301);
    run_r(vecs[2], 0);

    // Backpressure with a 2-deep FIFO: 3-piece request, no R returns yet.
    @(negedge clk);
    s_arvalid_b = 1'b1; s_araddr_b = 64'h0; s_arlen_b = 8'd191; s_arid_b = 16'h0007;
    #1;
    check("bp_ar_accept", {63'd0, s_arready_b}, 64'd1);
    @(negedge clk);
    s_arvalid_b = 1'b0;
    #1;
    check("bp_p0_valid", {63'd0, m_arvalid_b}, 64'd1);
    check("bp_p0_addr", m_araddr_b, 64'h0);
    @(negedge clk);
    #1;
    check("bp_p1_valid", {63'd0, m_arvalid_b}, 64'd1);
    check("bp_p1_addr", m_araddr_b, 64'h1000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("bp_stalled", {63'd0, m_arvalid_b}, 64'd0);
    end
    for (int b = 0; b < 64; b++) begin
      @(negedge clk);
      m_rvalid_b = 1'b1; m_rlast_b = (b == 63);
      #1;
      check("bp_full_no_valid", {63'd0, m_arvalid_b}, 64'd0);
      if (b == 63) check("bp_p0_rlast", {63'd0, s_rlast_b}, 64'd0);
    end
    @(negedge clk);
    m_rvalid_b = 1'b0; m_rlast_b = 1'b0;
    #1;
    check("bp_reassert", {63'd0, m_arvalid_b}, 64'd1);
    check("bp_p2_addr", m_araddr_b, 64'h2000);
    check("bp_p2_len", {56'd0, m_arlen_b}, 64'd63);
    @(negedge clk);
    #1;
    check("bp_done_valid", {63'd0, m_arvalid_b}, 64'd0);
    check("bp_full_ar_ready", {63'd0, s_arready_b}, 64'd0);
    for (int p = 1; p < 3; p++) begin
      for (int b = 0; b < 64; b++) begin
        @(negedge clk);
        m_rvalid_b = 1'b1; m_rlast_b = (b == 63);
        #1;
        if (b == 63) check("bp_piece_rlast", {63'd0, s_rlast_b}, {63'd0, (p == 2)});
      end
    end
    @(negedge clk);
    m_rvalid_b = 1'b0; m_rlast_b = 1'b0;
    #1;
    check("bp_drained_ar_ready", {63'd0, s_arready_b}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time bound (%0d/%0d checks passed)", n_pass, n_checks);
    $fatal(1);
  end

endmodule
